mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multicycle main controller for the single-memory MIPS datapath.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
- Drives the datapath mux selects, write enables and ALU control.
- Keeps a retired-instruction counter for simulation; sits beside the datapath, in place of the single-cycle combinational controller.

Parameters:
CNT_W, 32, width of retired-instruction counter instret.

Ports:
clka  in  1  clock
rst  in  1  synchronous reset, active-high
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory handshake; used only with MC_MEMWAIT_EN
pcen  out  1  PC write enable
iord  out  1  memory address select: 0=PC, 1=ALUOut
irwrite  out  1  instruction register load
memwrite  out  1  data memory write
regdst  out  1  0=rt, 1=rd
memtoreg  out  1  0=ALUOut, 1=MDR
regwrite  out  1  register file write
alusrca  out  1  0=PC, 1=rs
alusrcb  out  2  00=rt, 01=const 4, 10=signimm, 11=signimm<<2
pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal_op  out  1  one-cycle pulse on undecodable instruction
state  out  4  current state, for simulation
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset:
  - State = FETCH (0); instret = 0; latched op/funct = 0.
  - While rst=1, pcen, irwrite, memwrite, regwrite and illegal_op are forced to 0.
- Output timing:
  - All outputs are Moore-decoded from state.
  - Exception: pcen = pcwrite | (branch & zero).
  - Unlisted outputs are 0 in each state (alucontrol defaults to 010).
- States, encoding, outputs and next state:
  - 0 FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcwrite=1 -> DECODE.
  - 1 DECODE: alusrca=0, alusrcb=11, alucontrol=010. Latch op/funct. Next state by op:
    - lw 100011 or sw 101011 -> MEMADR
    - R-type 000000 with legal funct -> EXECUTE
    - beq 000100 -> BRANCH
    - addi 001000 -> ADDIEX
    - j 000010 -> JUMP
    - anything else -> FETCH, with illegal_op=1 for that cycle.
  - 2 MEMADR: alusrca=1, alusrcb=10, alucontrol=010 -> MEMRD if latched op=lw, else MEMWR.
  - 3 MEMRD: iord=1 -> MEMWB.
  - 4 MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - 5 MEMWR: iord=1, memwrite=1 -> FETCH.
  - 6 EXECUTE: alusrca=1, alusrcb=00, alucontrol from latched funct -> ALUWB. Funct mapping:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - Any other funct is illegal at DECODE.
  - 7 ALUWB: regdst=1, memtoreg=0, regwrite=1, alucontrol held -> FETCH.
  - 8 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1 -> FETCH.
  - 9 ADDIEX: alusrca=1, alusrcb=10, alucontrol=010 -> ADDIWB.
  - 10 ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - 11 JUMP: pcsrc=10, pcwrite=1 -> FETCH.
  - Codes 12-15: unreachable; recover to FETCH next cycle with all enables 0.
- Latencies (cycles per instruction):
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - illegal 2
- instret:
  - Increments by 1 on the cycle leaving MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
  - Wraps modulo 2^CNT_W; illegal instructions are not counted.
- rst asserted mid-instruction: the next edge goes to FETCH and aborts the instruction, with no write enable asserted during the rst cycle; instret clears.
- op/funct are sampled only in DECODE. Changes on op/funct in later states have no effect.

Optional Feature:
- Macro: MC_MEMWAIT_EN.
- Defined:
  - FETCH, MEMRD and MEMWR hold while mem_ready=0; outputs stay constant.
  - pcwrite/pcen and irwrite are asserted in FETCH only on the cycle mem_ready=1.
  - memwrite is held for every MEMWR cycle; the state advances on mem_ready=1.
- Undefined: mem_ready is ignored (tie 1); memory is single-cycle as above.

Test Plan:
- Reset: rst=1 for 2 cycles with op=100011 -> state=0, instret=0, pcen=irwrite=memwrite=regwrite=0; first cycle after release shows irwrite=1, pcen=1.
- lw (op=100011) -> states 0,1,2,3,4,0; memwrite=0 throughout; regwrite=1, memtoreg=1, regdst=0 only in state 4; instret 0->1.
- R-type sub (op=000000, funct=100010) -> states 0,1,6,7,0; alucontrol=110 in states 6 and 7; regwrite=1, regdst=1 in state 7. Repeat with funct=101010 -> alucontrol=111.
- beq (op=000100): zero=1 -> pcen=1, pcsrc=01 in state 8; zero=0 -> pcen=0. Both cases return to FETCH in 3 cycles.
- Illegal: op=111111, then op=000000 with funct=000111 -> illegal_op pulses for 1 cycle in DECODE, then state=0; instret unchanged. Also rst asserted during state 3 of lw -> state 0, no regwrite.
- With MC_MEMWAIT_EN, sw with mem_ready low for 3 cycles in MEMWR -> state stays 5 for 4 cycles with memwrite=1, then FETCH; FETCH with mem_ready=0 -> pcen=0.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller drives the master modport; the datapath owns the slave side.
interface mc_ctrl_fsm_if #(
   parameter int CNT_W = 32
);
   // Instruction fields and status flowing into the controller
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             zero;
   // mem_ready: memory accepts/completes the current access on any clka edge
   // where it is 1; the controller holds its state and outputs while it is 0.
   logic             mem_ready;

   // Datapath controls flowing out of the controller
   logic             pcen;
   logic             iord;
   logic             irwrite;
   logic             memwrite;
   logic             regdst;
   logic             memtoreg;
   logic             regwrite;
   logic             alusrca;
   logic [1:0]       alusrcb;
   logic [1:0]       pcsrc;
   logic [2:0]       alucontrol;
   logic             illegal_op;
   logic [3:0]       state;
   logic [CNT_W-1:0] instret;

   modport master (
      input  op, funct, zero, mem_ready,
      output pcen, iord, irwrite, memwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state, instret
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pcen, iord, irwrite, memwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state, instret
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller for the single-memory MIPS datapath.
// Define MC_MEMWAIT_EN to stall FETCH/MEMRD/MEMWR on bus.mem_ready.
module mc_ctrl_fsm #(
   parameter int CNT_W = 32
) (
   input  logic          clka,
   input  logic          rst,
   mc_ctrl_fsm_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q;
   state_t           state_d;
   logic [5:0]       op_q;
   logic [5:0]       funct_q;
   logic [CNT_W-1:0] instret_q;

   logic       mem_ok;
   logic       latch_instr;
   logic       retire;
   logic       pcwrite;
   logic       branch;
   logic       iord;
   logic       irwrite;
   logic       memwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic       illegal;

`ifdef MC_MEMWAIT_EN
   assign mem_ok = bus.mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   function automatic logic funct_legal(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
         default:                                               funct_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_alu = ALU_ADD;
      endcase
   endfunction

   always_ff @(posedge clka) begin
      if (rst) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         funct_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (latch_instr) begin
            op_q    <= bus.op;
            funct_q <= bus.funct;
         end
         if (retire) begin
            instret_q <= instret_q + CNT_ONE;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      latch_instr = 1'b0;
      retire      = 1'b0;
      pcwrite     = 1'b0;
      branch      = 1'b0;
      iord        = 1'b0;
      irwrite     = 1'b0;
      memwrite    = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsrc       = 2'b00;
      alucontrol  = ALU_ADD;
      illegal     = 1'b0;

      case (state_q)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = mem_ok;
            pcwrite = mem_ok;
            if (mem_ok) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb     = 2'b11;
            latch_instr = 1'b1;
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               OP_RTYPE: begin
                  if (funct_legal(bus.funct)) begin
                     state_d = S_EXECUTE;
                  end else begin
                     state_d = S_FETCH;
                     illegal = 1'b1;
                  end
               end
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord = 1'b1;
            if (mem_ok) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
            if (mem_ok) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECUTE: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu(funct_q);
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            alucontrol = funct_alu(funct_q);
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            branch     = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Write enables are killed during rst so an aborted instruction leaves no side effects
   assign bus.pcen       = ~rst & (pcwrite | (branch & bus.zero));
   assign bus.irwrite    = ~rst & irwrite;
   assign bus.memwrite   = ~rst & memwrite;
   assign bus.regwrite   = ~rst & regwrite;
   assign bus.illegal_op = ~rst & illegal;
   assign bus.iord       = iord;
   assign bus.regdst     = regdst;
   assign bus.memtoreg   = memtoreg;
   assign bus.alusrca    = alusrca;
   assign bus.alusrcb    = alusrcb;
   assign bus.pcsrc      = pcsrc;
   assign bus.alucontrol = alucontrol;
   assign bus.state      = state_q;
   assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: steps each instruction class through its states.
// Define MC_MEMWAIT_EN on both bench and RTL to exercise the memory-wait steps.
module tb_mc_ctrl_fsm;

   logic clka = 1'b0;
   logic rst  = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   mc_ctrl_fsm_if #(.CNT_W(32)) bus ();

   mc_ctrl_fsm #(.CNT_W(32)) dut (
      .clka (clka),
      .rst  (rst),
      .bus  (bus.master)
   );

   always #5 clka = ~clka;

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.op        = 6'b100011;
      bus.funct     = 6'b000000;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;

      // reset for two cycles
      tick();
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_instret", bus.instret, 32'd0);
      chk("rst_pcen", 32'(bus.pcen), 32'd0);
      chk("rst_irwrite", 32'(bus.irwrite), 32'd0);
      chk("rst_memwrite", 32'(bus.memwrite), 32'd0);
      chk("rst_regwrite", 32'(bus.regwrite), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("fetch_irwrite", 32'(bus.irwrite), 32'd1);
      chk("fetch_pcen", 32'(bus.pcen), 32'd1);
      chk("fetch_alusrcb", 32'(bus.alusrcb), 32'd1);

      // lw
      tick();
      chk("lw_s1", 32'(bus.state), 32'd1);
      chk("lw_s1_alusrcb", 32'(bus.alusrcb), 32'd3);
      tick();
      chk("lw_s2", 32'(bus.state), 32'd2);
      chk("lw_s2_alusrca", 32'(bus.alusrca), 32'd1);
      chk("lw_s2_alusrcb", 32'(bus.alusrcb), 32'd2);
      tick();
      chk("lw_s3", 32'(bus.state), 32'd3);
      chk("lw_s3_iord", 32'(bus.iord), 32'd1);
      chk("lw_s3_memwrite", 32'(bus.memwrite), 32'd0);
      chk("lw_s3_regwrite", 32'(bus.regwrite), 32'd0);
      tick();
      chk("lw_s4", 32'(bus.state), 32'd4);
      chk("lw_s4_regwrite", 32'(bus.regwrite), 32'd1);
      chk("lw_s4_memtoreg", 32'(bus.memtoreg), 32'd1);
      chk("lw_s4_regdst", 32'(bus.regdst), 32'd0);
      chk("lw_s4_instret", bus.instret, 32'd0);
      tick();
      chk("lw_done", 32'(bus.state), 32'd0);
      chk("lw_instret", bus.instret, 32'd1);

      // R-type sub; op changes after DECODE must be ignored
      bus.op    = 6'b000000;
      bus.funct = 6'b100010;
      tick();
      chk("sub_s1", 32'(bus.state), 32'd1);
      tick();
      bus.op    = 6'b111111;
      bus.funct = 6'b000111;
      #1;
      chk("sub_s6", 32'(bus.state), 32'd6);
      chk("sub_s6_alu", 32'(bus.alucontrol), 32'd6);
      tick();
      chk("sub_s7", 32'(bus.state), 32'd7);
      chk("sub_s7_alu", 32'(bus.alucontrol), 32'd6);
      chk("sub_s7_regwrite", 32'(bus.regwrite), 32'd1);
      chk("sub_s7_regdst", 32'(bus.regdst), 32'd1);
      tick();
      chk("sub_done", 32'(bus.state), 32'd0);
      chk("sub_instret", bus.instret, 32'd2);

      // R-type slt
      bus.op    = 6'b000000;
      bus.funct = 6'b101010;
      tick();
      tick();
      chk("slt_s6_alu", 32'(bus.alucontrol), 32'd7);
      tick();
      chk("slt_s7_alu", 32'(bus.alucontrol), 32'd7);
      tick();
      chk("slt_instret", bus.instret, 32'd3);

      // beq taken, then zero dropped within the same state
      bus.op   = 6'b000100;
      bus.zero = 1'b1;
      tick();
      tick();
      chk("beq_s8", 32'(bus.state), 32'd8);
      chk("beq_pcen_taken", 32'(bus.pcen), 32'd1);
      chk("beq_pcsrc", 32'(bus.pcsrc), 32'd1);
      chk("beq_alu", 32'(bus.alucontrol), 32'd6);
      bus.zero = 1'b0;
      #1;
      chk("beq_pcen_drop", 32'(bus.pcen), 32'd0);
      tick();
      chk("beq_done", 32'(bus.state), 32'd0);
      chk("beq_instret", bus.instret, 32'd4);

      // beq not taken
      tick();
      tick();
      chk("beqn_s8", 32'(bus.state), 32'd8);
      chk("beqn_pcen", 32'(bus.pcen), 32'd0);
      tick();
      chk("beqn_done", 32'(bus.state), 32'd0);
      chk("beqn_instret", bus.instret, 32'd5);

      // illegal opcode
      bus.op = 6'b111111;
      tick();
      chk("ill_op_s1", 32'(bus.state), 32'd1);
      chk("ill_op_pulse", 32'(bus.illegal_op), 32'd1);
      tick();
      chk("ill_op_s0", 32'(bus.state), 32'd0);
      chk("ill_op_clear", 32'(bus.illegal_op), 32'd0);
      chk("ill_op_instret", bus.instret, 32'd5);

      // illegal funct
      bus.op    = 6'b000000;
      bus.funct = 6'b000111;
      tick();
      chk("ill_fn_pulse", 32'(bus.illegal_op), 32'd1);
      tick();
      chk("ill_fn_s0", 32'(bus.state), 32'd0);
      chk("ill_fn_instret", bus.instret, 32'd5);

      // j
      bus.op = 6'b000010;
      tick();
      tick();
      chk("j_s11", 32'(bus.state), 32'd11);
      chk("j_pcen", 32'(bus.pcen), 32'd1);
      chk("j_pcsrc", 32'(bus.pcsrc), 32'd2);
      tick();
      chk("j_instret", bus.instret, 32'd6);

      // addi
      bus.op = 6'b001000;
      tick();
      tick();
      chk("addi_s9", 32'(bus.state), 32'd9);
      chk("addi_alusrcb", 32'(bus.alusrcb), 32'd2);
      tick();
      chk("addi_s10", 32'(bus.state), 32'd10);
      chk("addi_regwrite", 32'(bus.regwrite), 32'd1);
      chk("addi_regdst", 32'(bus.regdst), 32'd0);
      tick();
      chk("addi_instret", bus.instret, 32'd7);

      // sw
      bus.op = 6'b101011;
      tick();
      tick();
      tick();
      chk("sw_s5", 32'(bus.state), 32'd5);
      chk("sw_memwrite", 32'(bus.memwrite), 32'd1);
      chk("sw_iord", 32'(bus.iord), 32'd1);
      tick();
      chk("sw_done", 32'(bus.state), 32'd0);
      chk("sw_instret", bus.instret, 32'd8);

      // rst asserted in MEMRD of lw
      bus.op = 6'b100011;
      tick();
      tick();
      tick();
      chk("abort_s3", 32'(bus.state), 32'd3);
      rst = 1'b1;
      #1;
      chk("abort_regwrite", 32'(bus.regwrite), 32'd0);
      chk("abort_pcen", 32'(bus.pcen), 32'd0);
      tick();
      chk("abort_state", 32'(bus.state), 32'd0);
      chk("abort_regwrite2", 32'(bus.regwrite), 32'd0);
      chk("abort_instret", bus.instret, 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_refetch", 32'(bus.irwrite), 32'd1);

`ifdef MC_MEMWAIT_EN
      // sw stalled three cycles in MEMWR
      bus.op = 6'b101011;
      tick();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("wait_s5", 32'(bus.state), 32'd5);
         chk("wait_memwrite", 32'(bus.memwrite), 32'd1);
         tick();
      end
      chk("wait_s5_last", 32'(bus.state), 32'd5);
      chk("wait_memwrite_last", 32'(bus.memwrite), 32'd1);
      chk("wait_instret_hold", bus.instret, 32'd0);
      bus.mem_ready = 1'b1;
      tick();
      chk("wait_done", 32'(bus.state), 32'd0);
      chk("wait_instret", bus.instret, 32'd1);
      bus.mem_ready = 1'b0;
      #1;
      chk("wait_fetch_pcen", 32'(bus.pcen), 32'd0);
      chk("wait_fetch_irwrite", 32'(bus.irwrite), 32'd0);
      tick();
      chk("wait_fetch_hold", 32'(bus.state), 32'd0);
      bus.mem_ready = 1'b1;
      #1;
      chk("wait_fetch_go", 32'(bus.pcen), 32'd1);
      tick();
      chk("wait_fetch_s1", 32'(bus.state), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
